// File: rtl/serial_sub32.sv
// Multi-cycle unsigned subtractor: {bout, diff} = a - b - bin, CHUNK bits per cycle,
// with the borrow carried between chunks in a register. Valid/ready on both sides.
module serial_sub32 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned N  = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $fatal(1, "serial_sub32: CHUNK must be non-zero and divide WIDTH");
  end

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic             borrow_q, borrow_d, bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [31:0]      shamt;
  logic [WIDTH-1:0] a_sh, b_sh, chunk_mask, d_placed;
  logic [CHUNK:0]   sub_res;

  // Chunk k lives at bit offset k*CHUNK; shifts avoid a variable part-select.
  always_comb begin
    shamt      = 32'(cnt_q) * CHUNK;
    a_sh       = a_q >> shamt;
    b_sh       = b_q >> shamt;
    sub_res    = {1'b0, a_sh[CHUNK-1:0]} - {1'b0, b_sh[CHUNK-1:0]}
               - {{CHUNK{1'b0}}, borrow_q};
    chunk_mask = WIDTH'({CHUNK{1'b1}}) << shamt;
    d_placed   = WIDTH'(sub_res[CHUNK-1:0]) << shamt;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        diff_d   = (diff_q & ~chunk_mask) | d_placed;
        borrow_d = sub_res[CHUNK];
        if (cnt_q == CW'(N - 1)) begin
          bout_d  = sub_res[CHUNK];
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_serial_sub32.sv
// Directed self-checking bench for serial_sub32: hand-computed vectors, latency,
// backpressure hold and mid-operation reset.
module tb_serial_sub32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] diff;
  logic        bout;

  int n_tests = 0;
  int n_fail  = 0;

  serial_sub32 #(.WIDTH(32), .CHUNK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation, check latency and result, hold backpressure, then drain.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic bv_in, input logic [31:0] exp_d, input logic exp_b,
                        input int hold);
    int lat;
    logic [32:0] model;
    model = {1'b0, av} - {1'b0, bv} - 33'(bv_in);
    check_eq({tag, " in_ready"}, 64'(in_ready), 64'd1);
    a = av; b = bv; bin = bv_in; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; bin = 1'b1;
    lat = 1;
    while (!out_valid && lat <= 20) begin
      @(posedge clk); #1;
      lat++;
    end
    // lat counts edges after accept up to and including the one raising out_valid
    check_eq({tag, " latency"}, 64'(lat - 1), 64'd4);
    check_eq({tag, " diff"}, 64'(diff), 64'(exp_d));
    check_eq({tag, " bout"}, 64'(bout), 64'(exp_b));
    check_eq({tag, " model"}, {31'd0, bout, diff}, 64'(model));
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      @(posedge clk); #1;
      check_eq({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
      check_eq({tag, " hold diff"}, {31'd0, bout, diff}, {31'd0, exp_b, exp_d});
      check_eq({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, " drain out_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, " drain in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("reset in_ready", 64'(in_ready), 64'd1);
    check_eq("reset out_valid", 64'(out_valid), 64'd0);
    check_eq("reset diff", 64'(diff), 64'd0);
    check_eq("reset bout", 64'(bout), 64'd0);

    run_op("zero",   32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 0);
    run_op("wrap",   32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("vec3",   32'h1234_5678, 32'h8765_4321, 1'b1, 32'h8ACF_1356, 1'b1, 0);
    run_op("vec4",   32'hABCD_1234, 32'h1234_ABCD, 1'b1, 32'h9998_6666, 1'b0, 0);
    run_op("xchunk", 32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 0);
    run_op("eqbin",  32'h0000_0005, 32'h0000_0005, 1'b1, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("maxm1",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, 0);
    run_op("bp",     32'h1234_5678, 32'h8765_4321, 1'b1, 32'h8ACF_1356, 1'b1, 5);

    // Abort an operation after two chunks have been processed.
    a = 32'h0000_0000; b = 32'h0000_0001; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort out_valid", 64'(out_valid), 64'd0);
    check_eq("abort diff", 64'(diff), 64'd0);
    check_eq("abort bout", 64'(bout), 64'd0);
    check_eq("abort in_ready", 64'(in_ready), 64'd1);
    repeat (6) @(posedge clk);
    #1 check_eq("abort no result", 64'(out_valid), 64'd0);
    run_op("post", 32'hABCD_1234, 32'h1234_ABCD, 1'b1, 32'h9998_6666, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
